// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect controller for the 5-stage pipeline,
// sequencing data-bus wait states and iterative divides.
module pipe_hazard_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic              clk_100MHz,
   input  logic              arst_n,
   input  logic              ext_hold_i,
   input  logic              ld_use_req_i,
   input  logic              jump_req_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              div_start_i,
   input  logic              div_done_i,
   input  logic              mem_req_i,
   input  logic              mem_ack_i,
   output logic              hold_pc_o,
   output logic              hold_if_id_o,
   output logic              hold_id_ex_o,
   output logic              hold_ex_mem_o,
   output logic              hold_mem_wb_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic              flush_ex_mem_o,
   output logic              flush_mem_wb_o,
   output logic              pc_load_o,
   output logic [ADDR_W-1:0] pc_addr_o,
   output logic [1:0]        state_o,
   output logic              bus_timeout_o
);
   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, DIV_WAIT = 2'd2} state_t;
   state_t          st;
   logic [TO_W-1:0] cnt;
   logic            mem_miss, run, to_hit, stall_mem, stall_div, jmp, ldu, go, hx;
   always_comb begin
      mem_miss  = mem_req_i & !mem_ack_i;
      run       = st == RUN;
      to_hit    = cnt >= TO_W'(TIMEOUT);
      stall_mem = (run & mem_miss) | (st == MEM_WAIT & !mem_ack_i & !to_hit);
      stall_div = (run & !mem_miss & div_start_i) | (st == DIV_WAIT & !div_done_i);
      jmp       = run & !mem_miss & !div_start_i & jump_req_i;
      ldu       = run & !mem_miss & !div_start_i & !jump_req_i & ld_use_req_i;
      go        = arst_n & !ext_hold_i;
      hx        = arst_n & ext_hold_i;
   end
   // ext_hold_i freezes every stage and masks all flushes and redirects
   assign hold_pc_o      = hx | (go & (stall_mem | stall_div | ldu));
   assign hold_if_id_o   = hx | (go & (stall_mem | stall_div | ldu));
   assign hold_id_ex_o   = hx | (go & (stall_mem | stall_div));
   assign hold_ex_mem_o  = hx | (go & stall_mem);
   assign hold_mem_wb_o  = hx;
   assign flush_if_id_o  = go & jmp;
   assign flush_id_ex_o  = go & (jmp | ldu);
   assign flush_ex_mem_o = go & stall_div;
   assign flush_mem_wb_o = go & stall_mem;
   assign pc_load_o      = go & jmp;
   assign pc_addr_o      = pc_load_o ? jump_addr_i : '0;
   assign state_o        = st;
   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         st            <= RUN;
         cnt           <= '0;
         bus_timeout_o <= 1'b0;
      end else if (st == RUN) begin
         if (!ext_hold_i && mem_miss) begin
            st  <= MEM_WAIT;
            cnt <= TO_W'(1);
         end else if (!ext_hold_i && div_start_i) st <= DIV_WAIT;
      end else if (st == MEM_WAIT) begin
         if (mem_ack_i) begin
            st  <= RUN;
            cnt <= '0;
         end else if (!ext_hold_i && to_hit) begin
            st            <= RUN;
            cnt           <= '0;
            bus_timeout_o <= 1'b1;
         end else if (!ext_hold_i) cnt <= cnt + TO_W'(1);
      end else if (div_done_i) st <= RUN;
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus hand-written multi-cycle
// sequences for the hazard controller, built with TIMEOUT=4.
module tb_pipe_hazard_ctrl;
   logic        clk_100MHz = 0, arst_n = 0;
   logic        ext_hold_i, ld_use_req_i, jump_req_i, div_start_i, div_done_i, mem_req_i, mem_ack_i;
   logic [31:0] jump_addr_i, pc_addr_o;
   logic        hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o;
   logic        flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o, pc_load_o, bus_timeout_o;
   logic [1:0]  state_o;
   int          checks = 0, errors = 0;

   pipe_hazard_ctrl #(.ADDR_W(32), .TIMEOUT(4), .TO_W(3)) dut (
      .clk_100MHz(clk_100MHz), .arst_n(arst_n), .ext_hold_i(ext_hold_i),
      .ld_use_req_i(ld_use_req_i), .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
      .div_start_i(div_start_i), .div_done_i(div_done_i), .mem_req_i(mem_req_i),
      .mem_ack_i(mem_ack_i), .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o),
      .hold_id_ex_o(hold_id_ex_o), .hold_ex_mem_o(hold_ex_mem_o), .hold_mem_wb_o(hold_mem_wb_o),
      .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
      .flush_ex_mem_o(flush_ex_mem_o), .flush_mem_wb_o(flush_mem_wb_o),
      .pc_load_o(pc_load_o), .pc_addr_o(pc_addr_o), .state_o(state_o),
      .bus_timeout_o(bus_timeout_o)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   localparam logic [4:0] HM = 5'b11110, HD = 5'b11100, HL = 5'b11000, HX = 5'b11111;
   localparam logic [3:0] FM = 4'b0001, FD = 4'b0010, FL = 4'b0100, FJ = 4'b1100;

   logic [44:0] act;
   assign act = {hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o,
                 flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o,
                 pc_load_o, pc_addr_o, state_o, bus_timeout_o};

   function automatic logic [44:0] e(logic [4:0] h, logic [3:0] f, logic pl, logic [31:0] pa,
                                     logic [1:0] s, logic t);
      return {h, f, pl, pa, s, t};
   endfunction

   task automatic chk(string n, logic [44:0] x);
      checks++;
      if (act !== x) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, act, x);
      end
   endtask

   task automatic drv(logic xh, logic lu, logic jr, logic [31:0] ja, logic ds, logic dd,
                      logic mr, logic ma);
      @(negedge clk_100MHz);
      {ext_hold_i, ld_use_req_i, jump_req_i, jump_addr_i} = {xh, lu, jr, ja};
      {div_start_i, div_done_i, mem_req_i, mem_ack_i} = {ds, dd, mr, ma};
      #1;
   endtask

   typedef struct {
      string       n;
      logic [7:0]  in;
      logic [31:0] ja;
      logic [4:0]  h;
      logic [3:0]  f;
      logic        pl;
      logic [31:0] pa;
   } vec_t;
   vec_t tbl[12];

   initial begin
      // in = {xh, lu, jr, ds, dd, mr, ma, unused}; all vectors start and stay in RUN
      tbl[0]  = '{"idle",     8'b0000_0000, 32'h0,        5'b0, 4'b0, 1'b0, 32'h0};
      tbl[1]  = '{"ld_use",   8'b0100_0000, 32'h0,        HL,   FL,   1'b0, 32'h0};
      tbl[2]  = '{"ld_off",   8'b0000_0000, 32'h0,        5'b0, 4'b0, 1'b0, 32'h0};
      tbl[3]  = '{"jump",     8'b0010_0000, 32'h100,      5'b0, FJ,   1'b1, 32'h100};
      tbl[4]  = '{"jump_ldu", 8'b0110_0000, 32'h100,      5'b0, FJ,   1'b1, 32'h100};
      tbl[5]  = '{"mem_hit",  8'b0000_0110, 32'h0,        5'b0, 4'b0, 1'b0, 32'h0};
      tbl[6]  = '{"ack_only", 8'b0000_1010, 32'h0,        5'b0, 4'b0, 1'b0, 32'h0};
      tbl[7]  = '{"xh_jmp",   8'b1110_0000, 32'h100,      HX,   4'b0, 1'b0, 32'h0};
      tbl[8]  = '{"xh_mem",   8'b1000_0100, 32'h0,        HX,   4'b0, 1'b0, 32'h0};
      tbl[9]  = '{"xh_div",   8'b1001_0000, 32'h0,        HX,   4'b0, 1'b0, 32'h0};
      tbl[10] = '{"jump_big", 8'b0010_0000, 32'hDEADBEEF, 5'b0, FJ,   1'b1, 32'hDEADBEEF};
      tbl[11] = '{"idle2",    8'b0000_0000, 32'hDEADBEEF, 5'b0, 4'b0, 1'b0, 32'h0};

      // outputs must be zero during reset even with active requests
      {ext_hold_i, ld_use_req_i, jump_req_i, div_start_i} = 4'b1111;
      {div_done_i, mem_req_i, mem_ack_i} = 3'b010;
      jump_addr_i = 32'h40;
      #3 chk("reset", e(5'b0, 4'b0, 1'b0, 32'h0, 2'd0, 1'b0));
      @(negedge clk_100MHz) arst_n = 1;

      for (int i = 0; i < 12; i++) begin
         drv(tbl[i].in[7], tbl[i].in[6], tbl[i].in[5], tbl[i].ja, tbl[i].in[4], tbl[i].in[3],
             tbl[i].in[2], tbl[i].in[1]);
         chk(tbl[i].n, e(tbl[i].h, tbl[i].f, tbl[i].pl, tbl[i].pa, 2'd0, 1'b0));
      end

      // bus wait, ack in the fourth cycle
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("bw0", e(HM, FM, 0, 0, 0, 0));
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("bw1", e(HM, FM, 0, 0, 1, 0));
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("bw2", e(HM, FM, 0, 0, 1, 0));
      drv(0, 0, 0, 0, 0, 0, 1, 1); chk("bw_ack", e(0, 0, 0, 0, 1, 0));
      drv(0, 0, 0, 0, 0, 0, 0, 0); chk("bw_run", e(0, 0, 0, 0, 0, 0));

      // timeout after 4 held cycles, flag sticky
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("to0", e(HM, FM, 0, 0, 0, 0));
      for (int k = 1; k < 4; k++) begin
         drv(0, 0, 0, 0, 0, 0, 1, 0); chk("to_wait", e(HM, FM, 0, 0, 1, 0));
      end
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("to_rel", e(0, 0, 0, 0, 1, 0));
      drv(0, 0, 0, 0, 0, 0, 0, 0); chk("to_flag", e(0, 0, 0, 0, 0, 1));
      drv(0, 1, 0, 0, 0, 0, 0, 0); chk("to_sticky", e(HL, FL, 0, 0, 0, 1));

      @(negedge clk_100MHz) arst_n = 0;
      #1 chk("rst_clr", e(0, 0, 0, 0, 0, 0));
      @(negedge clk_100MHz) arst_n = 1;

      // ext hold with ack during MEM_WAIT
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("xa0", e(HM, FM, 0, 0, 0, 0));
      drv(1, 0, 0, 0, 0, 0, 1, 1); chk("xa_hold", e(HX, 0, 0, 0, 1, 0));
      drv(0, 0, 0, 0, 0, 0, 0, 0); chk("xa_run", e(0, 0, 0, 0, 0, 0));

      // ext hold freezes the wait counter, delaying the timeout by two cycles
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("fz0", e(HM, FM, 0, 0, 0, 0));
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("fz1", e(HM, FM, 0, 0, 1, 0));
      drv(1, 0, 0, 0, 0, 0, 1, 0); chk("fz_x1", e(HX, 0, 0, 0, 1, 0));
      drv(1, 0, 0, 0, 0, 0, 1, 0); chk("fz_x2", e(HX, 0, 0, 0, 1, 0));
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("fz2", e(HM, FM, 0, 0, 1, 0));
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("fz3", e(HM, FM, 0, 0, 1, 0));
      drv(0, 0, 0, 0, 0, 0, 1, 0); chk("fz_rel", e(0, 0, 0, 0, 1, 0));
      drv(0, 0, 0, 0, 0, 0, 0, 0); chk("fz_flag", e(0, 0, 0, 0, 0, 1));

      // divide with pending jump; done in the start cycle is ignored
      drv(0, 0, 1, 32'h200, 1, 1, 0, 0); chk("dv0", e(HD, FD, 0, 0, 0, 1));
      for (int k = 1; k < 5; k++) begin
         drv(0, 0, 1, 32'h200, 0, 0, 0, 0); chk("dv_wait", e(HD, FD, 0, 0, 2, 1));
      end
      drv(0, 0, 1, 32'h200, 0, 1, 0, 0); chk("dv_done", e(0, 0, 0, 0, 2, 1));
      drv(0, 0, 1, 32'h200, 0, 0, 0, 0); chk("dv_jump", e(0, FJ, 1, 32'h200, 0, 1));

      // reset in the middle of DIV_WAIT
      drv(0, 0, 0, 0, 1, 0, 0, 0); chk("dr0", e(HD, FD, 0, 0, 0, 1));
      drv(0, 0, 0, 0, 0, 0, 0, 0); chk("dr1", e(HD, FD, 0, 0, 2, 1));
      #2 arst_n = 0;
      #1 chk("rst_mid", e(0, 0, 0, 0, 0, 0));
      @(negedge clk_100MHz) arst_n = 1;
      drv(0, 0, 0, 0, 0, 0, 0, 0); chk("post_rst", e(0, 0, 0, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
